// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: address/data widths,
// arbiter FSM states, response owner encoding and a counter-width helper.
package dmem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;

    typedef enum logic {
        ARB,
        LOCK_B
    } arb_state_e;

    typedef enum logic {
        OWN_A,
        OWN_B
    } owner_e;

    // Bits needed to hold values 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter. The requester (MEM stage,
// loader, DMA) uses the master modport; the arbiter uses the slave modport.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          wack;

    modport master (
        output req, we, addr, wdata,
        input  ready, rvalid, rdata, wack
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rvalid, rdata, wack
    );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with clear and freeze. Clear together with inc
// restarts the count at 1; freeze holds the value regardless of clr/inc.
module sat_counter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             freeze,
    output logic [WIDTH-1:0] cnt
);

    // Count register: freeze wins over clear, clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!freeze) begin
            if (clr) begin
                cnt <= inc ? WIDTH'(1) : '0;
            end else if (inc && (cnt != WIDTH'(LIMIT))) begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares a single-port, 1-cycle-latency memory between
// port A (pipeline MEM stage, default priority) and port B (loader/debug/DMA).
// One access issues per cycle; the response is routed to its owner the next
// cycle. B is protected from starvation and may lock the memory for
// read-modify-write sequences, with a forced release after LOCK_MAX cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 16
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave a,
    dmem_arbiter_if.slave b,
    input  logic          b_lock,
    output logic          lock_abort,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_wd
);

    localparam int SW = cnt_width(STARVE_LIMIT);
    localparam int LW = cnt_width(LOCK_MAX);

    arb_state_e    state_q, state_d;
    logic          lock_blk_q, lock_blk_d;
    logic          lock_enter;
    logic          grant_a, grant_b;
    logic [SW-1:0] starve_cnt;
    logic [LW-1:0] lock_cnt;

    logic          vld_p1;
    owner_e        own_p1;
    logic          we_p1;

    // FSM state and lock-block flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            lock_blk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_blk_q <= lock_blk_d;
        end
    end

    // Grant selection, lock entry/exit and forced release; no grants while in reset.
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_d    = state_q;
        lock_blk_d = lock_blk_q;
        lock_abort = 1'b0;
        lock_enter = 1'b0;
        if (!rst) begin
            case (state_q)
                ARB: begin
                    if (b.req && (starve_cnt == SW'(STARVE_LIMIT))) begin
                        grant_b = 1'b1;
                    end else if (a.req) begin
                        grant_a = 1'b1;
                    end else if (b.req) begin
                        grant_b = 1'b1;
                    end
                    // After a forced release, B must drop b_lock once before relocking.
                    if (lock_blk_q && !b_lock) begin
                        lock_blk_d = 1'b0;
                    end
                    if (grant_b && b_lock && !lock_blk_q) begin
                        state_d    = LOCK_B;
                        lock_enter = 1'b1;
                    end
                end
                LOCK_B: begin
                    grant_b = b.req;
                    if (!b_lock) begin
                        state_d = ARB;
                    end else if (lock_cnt == LW'(LOCK_MAX)) begin
                        state_d    = ARB;
                        lock_abort = 1'b1;
                        lock_blk_d = 1'b1;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    sat_counter #(
        .WIDTH (SW),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    ((state_q == ARB) && b.req && !grant_b),
        .clr    (!b.req || grant_b),
        .freeze (state_q == LOCK_B),
        .cnt    (starve_cnt)
    );

    sat_counter #(
        .WIDTH (LW),
        .LIMIT (LOCK_MAX)
    ) u_lock_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (lock_enter || (state_q == LOCK_B)),
        .clr    (state_q == ARB),
        .freeze (1'b0),
        .cnt    (lock_cnt)
    );

    assign a.ready   = grant_a;
    assign b.ready   = grant_b;
    assign mem_addr  = grant_b ? b.addr  : a.addr;
    assign mem_wdata = grant_b ? b.wdata : a.wdata;
    assign mem_we    = (grant_a && a.we) || (grant_b && b.we);

    // Issue -> response stage: remember who owns the access returning next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            own_p1 <= OWN_A;
            we_p1  <= 1'b0;
        end else begin
            vld_p1 <= grant_a || grant_b;
            own_p1 <= grant_b ? OWN_B : OWN_A;
            we_p1  <= mem_we;
        end
    end

    // Responses are suppressed while rst is high so a reset drops the in-flight one.
    assign a.rvalid = vld_p1 && !rst && (own_p1 == OWN_A) && !we_p1;
    assign b.rvalid = vld_p1 && !rst && (own_p1 == OWN_B) && !we_p1;
    assign a.wack   = vld_p1 && !rst && (own_p1 == OWN_A) && we_p1 && mem_wd;
    assign b.wack   = vld_p1 && !rst && (own_p1 == OWN_B) && we_p1 && mem_wd;
    assign a.rdata  = a.rvalid ? mem_rdata : '0;
    assign b.rdata  = b.rvalid ? mem_rdata : '0;

endmodule
